// File: rtl/conv1_pkg.sv
// conv1_pkg: shared types and helpers for the conv1 intermediate drain.
// Holds the drain FSM state type and the lane-index width function.
package conv1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } conv1_drain_state_t;

  // Index wide enough to address every lane, never narrower than one bit.
  function automatic int conv1_lane_idx_width(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/conv1_intrm_drain_if.sv
// conv1_intrm_drain_if: vector-in / result-out handshake bundle for the drain.
// The slave modport is the drain itself; master is its upstream/downstream side.
interface conv1_intrm_drain_if #(
  parameter int NUM_INPUTS = 5,
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 32
);

  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [OUT_WIDTH-1:0]           out_data_o;
  logic                           out_sat_o;
  logic                           busy_o;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_sat_o,
    output busy_o
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_sat_o,
    input  busy_o
  );

endinterface

// File: rtl/conv1_drain_clamp.sv
// conv1_drain_clamp: combinational rescale and narrowing of the final lane sum.
// CONV1_DRAIN_SAT_EN selects signed saturation; otherwise the result wraps.
module conv1_drain_clamp #(
  parameter int ACC_WIDTH  = 68,
  parameter int FRAC_SHIFT = 16,
  parameter int OUT_WIDTH  = 32
) (
  input  logic signed [ACC_WIDTH-1:0] final_sum,
  output logic        [OUT_WIDTH-1:0] result,
  output logic                        sat
);

  logic signed [ACC_WIDTH-1:0] shifted;

  // Arithmetic shift keeps the sign, so rounding is toward minus infinity.
  assign shifted = final_sum >>> FRAC_SHIFT;

`ifdef CONV1_DRAIN_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    result = shifted[OUT_WIDTH-1:0];
    sat    = 1'b0;
    if (shifted > OUT_MAX) begin
      result = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat    = 1'b1;
    end else if (shifted < OUT_MIN) begin
      result = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat    = 1'b1;
    end
  end
`else
  // Bits above the result are intentionally discarded by the wrap.
  logic unused_high;

  assign unused_high = ^shifted[ACC_WIDTH-1:OUT_WIDTH];
  assign result      = shifted[OUT_WIDTH-1:0];
  assign sat         = 1'b0;
`endif

endmodule

// File: rtl/conv1_intrm_drain.sv
// conv1_intrm_drain: serially sums one captured vector of signed lanes and hands
// a rescaled result downstream. Optional saturation via CONV1_DRAIN_SAT_EN.
module conv1_intrm_drain
  import conv1_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int IN_WIDTH   = 64,
  parameter int ACC_WIDTH  = 68,
  parameter int FRAC_SHIFT = 16,
  parameter int OUT_WIDTH  = 32
) (
  input  logic               drain_clk,
  input  logic               drain_rst_b,
  conv1_intrm_drain_if.slave bus
);

  localparam int                IDX_W    = conv1_lane_idx_width(NUM_INPUTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  // The accumulator must absorb every lane without overflow.
  generate
    if (NUM_INPUTS < 2) begin : g_bad_lanes
      $error("conv1_intrm_drain: NUM_INPUTS must be at least 2");
    end
    if (ACC_WIDTH < IN_WIDTH + $clog2(NUM_INPUTS)) begin : g_bad_acc
      $error("conv1_intrm_drain: ACC_WIDTH too narrow for NUM_INPUTS lanes");
    end
    if (ACC_WIDTH <= OUT_WIDTH) begin : g_bad_out
      $error("conv1_intrm_drain: ACC_WIDTH must exceed OUT_WIDTH");
    end
  endgenerate

  conv1_drain_state_t           state_q;
  conv1_drain_state_t           state_d;
  logic signed [IN_WIDTH-1:0]   lane_q [NUM_INPUTS];
  logic        [IDX_W-1:0]      idx_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [IN_WIDTH-1:0]   lane_cur;
  logic signed [ACC_WIDTH-1:0]  lane_ext;
  logic signed [ACC_WIDTH-1:0]  final_sum;
  logic        [OUT_WIDTH-1:0]  narrowed;
  logic                         narrowed_sat;
  logic        [OUT_WIDTH-1:0]  out_data_q;
  logic                         out_sat_q;
  logic                         accept;
  logic                         accum_en;
  logic                         finish;

  assign lane_cur  = lane_q[idx_q];
  assign lane_ext  = {{(ACC_WIDTH-IN_WIDTH){lane_cur[IN_WIDTH-1]}}, lane_cur};
  assign final_sum = acc_q + lane_ext;

  conv1_drain_clamp #(
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_clamp (
    .final_sum (final_sum),
    .result    (narrowed),
    .sat       (narrowed_sat)
  );

  always_ff @(posedge drain_clk or negedge drain_rst_b) begin
    if (!drain_rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshakes only take effect in their own state; inputs are ignored elsewhere.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    accum_en = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          accept  = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accum_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lane buffer is the only copy of the vector, so upstream may move on at once.
  always_ff @(posedge drain_clk or negedge drain_rst_b) begin
    if (!drain_rst_b) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        lane_q[i] <= '0;
      end
      idx_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          lane_q[i] <= bus.in_data_i[i*IN_WIDTH +: IN_WIDTH];
        end
        idx_q <= '0;
        acc_q <= '0;
      end else if (accum_en) begin
        acc_q <= final_sum;
        if (!finish) begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
      if (finish) begin
        out_data_q <= narrowed;
        out_sat_q  <= narrowed_sat;
      end
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.out_data_o  = out_data_q;
  assign bus.out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_conv1_intrm_drain.sv
// tb_conv1_intrm_drain: randomized and directed checks of conv1_intrm_drain
// against a lane-sum reference model; honours CONV1_DRAIN_SAT_EN when defined.
module tb_conv1_intrm_drain;

  localparam int N    = 5;
  localparam int IW   = 64;
  localparam int OW   = 32;
  localparam int VECW = N * IW;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  always #5 clk = ~clk;

  conv1_intrm_drain_if #(.NUM_INPUTS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  conv1_intrm_drain #(
    .NUM_INPUTS (N),
    .IN_WIDTH   (IW),
    .ACC_WIDTH  (68),
    .FRAC_SHIFT (16),
    .OUT_WIDTH  (OW)
  ) dut (
    .drain_clk   (clk),
    .drain_rst_b (rst_b),
    .bus         (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum of the signed lanes, floor-scaled, then wrapped or clamped.
  function automatic logic [32:0] ref_result(input logic [VECW-1:0] vec);
    logic signed [67:0] sum;
    logic signed [67:0] shifted;
    logic signed [63:0] lane;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      lane = vec[i*IW +: IW];
      sum  = sum + lane;
    end
    shifted = sum >>> 16;
`ifdef CONV1_DRAIN_SAT_EN
    if (shifted > 68'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (shifted < -68'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    return {1'b0, shifted[31:0]};
  endfunction

  function automatic logic [VECW-1:0] fill(input logic [63:0] lane);
    return {N{lane}};
  endfunction

  function automatic logic [VECW-1:0] rand_vec();
    logic [VECW-1:0]    v;
    logic signed [31:0] ip;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: v[i*IW +: IW] = {$urandom, $urandom};
        1: begin
          ip = $signed($urandom_range(0, 2000)) - 1000;
          v[i*IW +: IW] = {ip, $urandom};
        end
        2: v[i*IW +: IW] = {32'h0000_7000 + 32'($urandom_range(0, 4095)), $urandom};
        default: v[i*IW +: IW] = {32'hFFFF_8000 + 32'($urandom_range(0, 4095)), $urandom};
      endcase
    end
    return v;
  endfunction

  // Accepts one vector and waits for its result; leaves the DUT in DONE.
  task automatic applyStimulus(input logic [VECW-1:0] vec, input string tag);
    int          cycles;
    logic [32:0] exp;
    exp    = ref_result(vec);
    cycles = 0;
    while (!bus.in_ready_o && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = vec;
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = {10{$urandom}};
    checkOutput({tag, "_busy"}, bus.busy_o, 1'b1);
    cycles = 0;
    while (!bus.out_valid_o && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, N);
    checkOutput({tag, "_data"}, bus.out_data_o, exp[31:0]);
    checkOutput({tag, "_sat"}, bus.out_sat_o, exp[32]);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready_i = 1'b1;
    tick();
    checkOutput({tag, "_ret_idle"}, bus.in_ready_o, 1'b1);
    checkOutput({tag, "_valid_drop"}, bus.out_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VECW-1:0] vecs [4];
    logic [32:0]     exps [4];
    int              accepts[$];
    int              seen;
    int              k;
    int              cyc;
    int              stray;
    logic            acc_now;
    logic [31:0]     held;

    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b1;

    repeat (3) tick();
    checkOutput("rst_in_ready", bus.in_ready_o, 1'b1);
    checkOutput("rst_out_valid", bus.out_valid_o, 1'b0);
    checkOutput("rst_out_data", bus.out_data_o, 32'h0);
    checkOutput("rst_out_sat", bus.out_sat_o, 1'b0);
    checkOutput("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    $display("[TB] directed vectors");
    applyStimulus(fill(64'h0000_0001_0000_0000), "one");
    checkOutput("one_const", bus.out_data_o, 32'h0005_0000);
    release_result("one");
    applyStimulus(fill(64'hFFFF_FFFF_0000_0000), "neg_one");
    checkOutput("neg_one_const", bus.out_data_o, 32'hFFFB_0000);
    release_result("neg_one");
    applyStimulus(fill(64'h0000_7FFF_0000_0000), "big");
`ifdef CONV1_DRAIN_SAT_EN
    checkOutput("big_const", bus.out_data_o, 32'h7FFF_FFFF);
    checkOutput("big_sat_const", bus.out_sat_o, 1'b1);
`else
    checkOutput("big_const", bus.out_data_o, 32'h7FFB_0000);
    checkOutput("big_sat_const", bus.out_sat_o, 1'b0);
`endif
    release_result("big");

    $display("[TB] stall in DONE");
    bus.out_ready_i = 1'b0;
    applyStimulus(fill(64'h0000_0003_8000_0000), "stall");
    held = ref_result(fill(64'h0000_0003_8000_0000)) & 33'h0_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i = ~bus.in_valid_i;
      bus.in_data_i  = rand_vec();
      tick();
      checkOutput("stall_valid", bus.out_valid_o, 1'b1);
      checkOutput("stall_data", bus.out_data_o, held);
      checkOutput("stall_in_ready", bus.in_ready_o, 1'b0);
    end
    bus.in_valid_i = 1'b0;
    release_result("stall");
    stray = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid_o || bus.busy_o) stray++;
    end
    checkOutput("stall_no_capture", stray, 0);

    $display("[TB] reset during accumulation");
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = fill(64'h0000_0004_0000_0000);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    #2 rst_b = 1'b0;
    #1;
    checkOutput("midrst_in_ready", bus.in_ready_o, 1'b1);
    checkOutput("midrst_out_valid", bus.out_valid_o, 1'b0);
    checkOutput("midrst_out_data", bus.out_data_o, 32'h0);
    checkOutput("midrst_out_sat", bus.out_sat_o, 1'b0);
    checkOutput("midrst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    stray = 0;
    repeat (12) begin
      tick();
      if (bus.out_valid_o) stray++;
    end
    checkOutput("midrst_no_pulse", stray, 0);
    applyStimulus(fill(64'h0000_0002_0000_0000), "two");
    checkOutput("two_const", bus.out_data_o, 32'h000A_0000);
    release_result("two");

    $display("[TB] back-to-back vectors");
    for (int i = 0; i < 4; i++) begin
      vecs[i] = rand_vec();
      exps[i] = ref_result(vecs[i]);
    end
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = vecs[0];
    k    = 0;
    seen = 0;
    cyc  = 0;
    while (seen < 4 && cyc < 200) begin
      acc_now = bus.in_valid_i && bus.in_ready_o;
      if (bus.out_valid_o) begin
        checkOutput("b2b_data", bus.out_data_o, exps[seen][31:0]);
        checkOutput("b2b_sat", bus.out_sat_o, exps[seen][32]);
        seen++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        accepts.push_back(cyc);
        k++;
        if (k < 4) bus.in_data_i = vecs[k];
        else bus.in_valid_i = 1'b0;
      end
    end
    bus.in_valid_i = 1'b0;
    checkOutput("b2b_results", seen, 4);
    checkOutput("b2b_accepts", accepts.size(), 4);
    for (int i = 1; i < accepts.size(); i++) begin
      checkOutput("b2b_gap", accepts[i] - accepts[i-1], N + 2);
    end
    tick();

    $display("[TB] randomized vectors");
    for (int i = 0; i < 25; i++) begin
      bus.out_ready_i = 1'($urandom_range(0, 1));
      applyStimulus(rand_vec(), "rand");
      if (!bus.out_ready_i) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          checkOutput("rand_hold_valid", bus.out_valid_o, 1'b1);
        end
      end
      release_result("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/conv1_intrm_drain.md
# conv1_intrm_drain

Reader side of the conv1 intermediate flop bank. It accepts one captured vector of NUM_INPUTS signed fixed-point products over a valid/ready handshake and sums the lanes serially, one per cycle, into a wide accumulator. It then rescales the sum and presents a single OUT_WIDTH result to the next conv1 stage over a second valid/ready handshake.

## Interface
- NUM_INPUTS, 5, lanes per vector (≥2)
- IN_WIDTH, 64, width of each signed product lane (Q32.32)
- ACC_WIDTH, 68, signed accumulator width; must be ≥ IN_WIDTH + $clog2(NUM_INPUTS)
- FRAC_SHIFT, 16, arithmetic right shift applied to the final sum before narrowing
- OUT_WIDTH, 32, signed result width (Q16.16 with defaults)

Ports:
- drain_clk  in  1  clock; all state updates on the rising edge
- drain_rst_b  in  1  asynchronous, active-low reset
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  block can accept a vector; high only in IDLE
- in_data_i  in  NUM_INPUTS×IN_WIDTH  packed lanes, lane 0 in the LSBs
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- out_data_o  out  OUT_WIDTH  signed result
- out_sat_o  out  1  result was clamped; qualified by out_valid_o
- busy_o  out  1  high in ACCUM or DONE

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o: register in_data_i into the lane buffer, clear the accumulator, set lane index to 0, go to ACCUM.
- ACCUM:
  - Each cycle, acc <= acc + sign_extend(lane[idx]) and idx increments.
  - On idx == NUM_INPUTS-1, form final = acc + lane[idx]; register the narrowed result into out_data_o and out_sat_o; go to DONE.
- Narrowing: shifted = final >>> FRAC_SHIFT (arithmetic shift, floor rounding).
  - Without the macro: out_data_o = shifted[OUT_WIDTH-1:0], i.e. two's-complement wrap.
- DONE:
  - out_valid_o = 1.
  - out_data_o and out_sat_o are held stable until out_valid_o && out_ready_i; that handshake returns the FSM to IDLE.
- in_data_i and in_valid_i are ignored outside IDLE. The lane buffer is the only copy, so upstream may change its flops immediately after the accept.
- Accumulator overflow cannot occur when the ACC_WIDTH rule holds. Elaboration fails if the rule is violated.
- Reset, asynchronous at any time including mid-ACCUM:
  - State returns to IDLE.
  - The in-flight vector is discarded; no partial result is ever emitted.
- Output reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_sat_o=0, busy_o=0.

## Timing
- Accept edge T. ACCUM edges run from T+1 to T+NUM_INPUTS.
- out_valid_o rises after edge T+NUM_INPUTS, giving a latency of NUM_INPUTS cycles from accept to valid.
- With out_ready_i held high, DONE lasts one cycle and in_ready_o returns after edge T+NUM_INPUTS+1.
- Peak throughput: one vector per NUM_INPUTS+2 cycles.
- No combinational path from any input to any output except in_ready_o and busy_o, which decode only the state register.
- out_ready_i may be asserted before out_valid_o; it takes effect only in DONE.

## Configuration
- CONV1_DRAIN_SAT_EN defined:
  - If shifted exceeds the signed OUT_WIDTH range, out_data_o clamps to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1), and out_sat_o=1.
  - Otherwise behaviour matches the undefined case.
- CONV1_DRAIN_SAT_EN undefined:
  - Wrap as described under Operation.
  - out_sat_o is tied to 0 and no clamp logic is synthesised.

## Structure
- conv1_pkg holds the FSM state enum typedef (conv1_drain_state_t) and the lane-index width constant function.
- One sub-module, conv1_drain_clamp, does the narrowing: arithmetic shift plus the clamp/wrap selected by CONV1_DRAIN_SAT_EN. Its inputs are the final sum; its outputs are the narrowed result and the sat flag. It is purely combinational and is registered by the parent.

## Test plan
All scenarios use default parameters.
- Five lanes of 0x0000_0001_0000_0000 (1.0), accepted at edge 0, out_ready_i=1 -> out_valid_o high after edge 5, out_data_o=0x0005_0000, out_sat_o=0, in_ready_o high after edge 6.
- Five lanes of 0xFFFF_FFFF_0000_0000 (-1.0) -> out_data_o=0xFFFB_0000.
- Five lanes of 0x0000_7FFF_0000_0000 (32767.0):
  - With CONV1_DRAIN_SAT_EN -> out_data_o=0x7FFF_FFFF, out_sat_o=1.
  - Without it -> out_data_o=0x7FFB_0000, out_sat_o=0.
- out_ready_i held low for 10 cycles in DONE while in_valid_i toggles with new data -> out_valid_o and out_data_o stay stable, in_ready_o stays 0, and the new data is not captured. When out_ready_i rises, the FSM returns to IDLE one edge later.
- drain_rst_b pulsed low during ACCUM at lane 2 -> outputs immediately take their reset values and no out_valid_o pulse follows. A fresh vector of 2.0 lanes after release -> 0x000A_0000.
- Back-to-back vectors, with in_valid_i held high and out_ready_i=1 -> accepts are exactly 7 cycles apart and results emerge in order.
